data_mem_hs: RTL and testbench

DATA_MEM_HS -- requirements
Module: data_mem_hs

---
 rtl/data_mem_hs_pkg.sv | 32 +++
 rtl/data_mem_hs_if.sv | 24 ++
 rtl/data_mem_hs_lane_align.sv | 52 +++++
 rtl/data_mem_hs.sv | 179 +++++++++++++++++
 tb/tb_data_mem_hs.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_hs_pkg.sv
// Shared types for the handshaked data memory: access-size encodings, FSM
// states, latency limit and the alignment/size error helper.
package data_mem_hs_pkg;

  localparam int LAT_MAX = 15;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Size/alignment part of the error decision; the range check lives in the top.
  function automatic logic size_addr_err(input logic [1:0] size, input logic [1:0] addr_lo);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = addr_lo[0];
      SZ_WORD: err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/data_mem_hs_if.sv
// Request/response handshake bundle of the data memory.
interface data_mem_hs_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_hs_lane_align.sv
// Byte-lane steering shared by the store-merge and load paths: merges store
// data into the addressed lanes and extracts/extends load data.
module dmem_lane_align
  import data_mem_hs_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] mem_word,
  input  logic [1:0]  byte_off,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  output logic [31:0] st_word,
  output logic [31:0] ld_data
);

  logic [4:0]  shamt_s;
  logic [31:0] lane_mask_s;
  logic [31:0] shifted_s;

  // Bit offset of the addressed item inside the word and its lane mask.
  always_comb begin
    shamt_s     = 5'd0;
    lane_mask_s = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: begin
        shamt_s     = BIG_ENDIAN ? {2'd3 - byte_off, 3'b000} : {byte_off, 3'b000};
        lane_mask_s = 32'h0000_00FF;
      end
      SZ_HALF: begin
        shamt_s     = BIG_ENDIAN ? {2'd2 - byte_off, 3'b000} : {byte_off, 3'b000};
        lane_mask_s = 32'h0000_FFFF;
      end
      default: begin
        shamt_s     = 5'd0;
        lane_mask_s = 32'hFFFF_FFFF;
      end
    endcase
  end

  // Load extraction with sign/zero extension, and read-modify-write merge.
  always_comb begin
    shifted_s = mem_word >> shamt_s;
    case (size)
      SZ_BYTE: ld_data = {{24{is_signed & shifted_s[7]}}, shifted_s[7:0]};
      SZ_HALF: ld_data = {{16{is_signed & shifted_s[15]}}, shifted_s[15:0]};
      default: ld_data = shifted_s;
    endcase
    st_word = (mem_word & ~(lane_mask_s << shamt_s)) | ((wdata & lane_mask_s) << shamt_s);
  end

endmodule

// File: rtl/data_mem_hs.sv
// Word-organised data memory behind a valid/ready request/response handshake
// with a fixed programmable access latency.
module data_mem_hs
  import data_mem_hs_pkg::*;
#(
  parameter int WORDS      = 1024,
  parameter int LATENCY    = 2,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  data_mem_hs_if.slave  bus
);

  localparam int          IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [31:0] BYTE_CAP = 32'(4 * WORDS);
  localparam logic [3:0]  LAT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic [31:0] mem_q [WORDS];

  logic        acc_we_s, acc_signed_s;
  logic [1:0]  acc_size_s;
  logic [31:0] acc_addr_s, acc_wdata_s;
  logic [IDX_W-1:0] idx_s;
  logic        in_range_s, err_s, access_s, mem_we_s;
  logic [31:0] rd_word_s, st_word_s, ld_data_s;

  // With zero latency the access happens on the accept edge, so it uses the live request.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we_s     = bus.req_we;
      acc_size_s   = bus.req_size;
      acc_signed_s = bus.req_signed;
      acc_addr_s   = bus.req_addr;
      acc_wdata_s  = bus.req_wdata;
    end else begin
      acc_we_s     = we_q;
      acc_size_s   = size_q;
      acc_signed_s = signed_q;
      acc_addr_s   = addr_q;
      acc_wdata_s  = wdata_q;
    end
  end

  assign idx_s      = acc_addr_s[IDX_W+1:2];
  assign in_range_s = (acc_addr_s < BYTE_CAP);
  assign err_s      = !in_range_s || size_addr_err(acc_size_s, acc_addr_s[1:0]);
  assign rd_word_s  = in_range_s ? mem_q[idx_s] : 32'd0;

  dmem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .mem_word  (rd_word_s),
    .byte_off  (acc_addr_s[1:0]),
    .size      (acc_size_s),
    .is_signed (acc_signed_s),
    .wdata     (acc_wdata_s),
    .st_word   (st_word_s),
    .ld_data   (ld_data_s)
  );

  // Next-state, capture and response logic of the handshake FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    access_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          we_d     = bus.req_we;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          if (LATENCY == 0) begin
            access_s = 1'b1;
            state_d  = ST_RESP;
          end else begin
            cnt_d   = LAT_INIT;
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          access_s = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'd0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (access_s) begin
      rsp_err_d   = err_s;
      rsp_rdata_d = (err_s || acc_we_s) ? 32'd0 : ld_data_s;
    end else begin
      rsp_err_d   = rsp_err_d;
      rsp_rdata_d = rsp_rdata_d;
    end
    rsp_valid_d = (state_d == ST_RESP);
    req_ready_d = (state_d == ST_IDLE);
  end

  assign mem_we_s = access_s && acc_we_s && !err_s && !reset;

  // Control and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= st_word_s;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_hs.sv
// Scoreboard bench: one big-endian LATENCY=2 instance and one little-endian
// LATENCY=0 instance driven from a shared set of request variables.
module tb_data_mem_hs;
  import data_mem_hs_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_b;
  logic t_valid, t_we, t_signed, t_rsp_ready;
  logic [1:0]  t_size;
  logic [31:0] t_addr, t_wdata;
  int sel;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  data_mem_hs_if bus_a();
  data_mem_hs_if bus_b();

  data_mem_hs #(.WORDS(1024), .LATENCY(2), .BIG_ENDIAN(1'b1)) dut_a (
    .clk(clk), .reset(reset_a), .bus(bus_a.slave));
  data_mem_hs #(.WORDS(1024), .LATENCY(0), .BIG_ENDIAN(1'b0)) dut_b (
    .clk(clk), .reset(reset_b), .bus(bus_b.slave));

  assign bus_a.req_valid  = t_valid && (sel == 0);
  assign bus_a.req_we     = t_we;
  assign bus_a.req_size   = t_size;
  assign bus_a.req_signed = t_signed;
  assign bus_a.req_addr   = t_addr;
  assign bus_a.req_wdata  = t_wdata;
  assign bus_a.rsp_ready  = t_rsp_ready;
  assign bus_b.req_valid  = t_valid && (sel == 1);
  assign bus_b.req_we     = t_we;
  assign bus_b.req_size   = t_size;
  assign bus_b.req_signed = t_signed;
  assign bus_b.req_addr   = t_addr;
  assign bus_b.req_wdata  = t_wdata;
  assign bus_b.rsp_ready  = t_rsp_ready;

  logic        o_ready, o_valid, o_err;
  logic [31:0] o_rdata;
  assign o_ready = (sel == 0) ? bus_a.req_ready : bus_b.req_ready;
  assign o_valid = (sel == 0) ? bus_a.rsp_valid : bus_b.rsp_valid;
  assign o_err   = (sel == 0) ? bus_a.rsp_err   : bus_b.rsp_err;
  assign o_rdata = (sel == 0) ? bus_a.rsp_rdata : bus_b.rsp_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Drive a request at a negedge and return just after the accepting edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    t_we = we; t_size = size; t_signed = sgn; t_addr = addr; t_wdata = wdata;
    t_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      check_eq("accept_timeout", 32'd0, 32'd1);
    end
    // Garbage on the request lines while busy must not matter.
    t_valid  = 1'b0;
    t_we     = ~we;
    t_size   = 2'($urandom_range(0, 3));
    t_signed = ~sgn;
    t_addr   = $urandom;
    t_wdata  = $urandom;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    @(negedge clk);
    while (!o_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic txn(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    exp_t e;
    bit ok;
    int n;
    logic [31:0] snap_d;
    logic snap_e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = (sel == 0) ? 3 : 1;
    sb_q.push_back(e);
    t_rsp_ready = (hold == 0);
    issue(we, size, sgn, addr, wdata, ok);
    e = sb_q.pop_front();
    if (!ok) begin
      t_rsp_ready = 1'b1;
      return;
    end
    wait_valid(n);
    if (!o_valid) begin
      check_eq({tag, "_rsp_timeout"}, 32'd0, 32'd1);
      t_rsp_ready = 1'b1;
      return;
    end
    check_eq({tag, "_lat"}, n, e.lat);
    check_eq({tag, "_rdata"}, o_rdata, e.rdata);
    check_eq({tag, "_err"}, {31'd0, o_err}, {31'd0, e.err});
    if (hold > 0) begin
      snap_d = o_rdata;
      snap_e = o_err;
      repeat (hold) begin
        @(negedge clk);
        check_eq({tag, "_hold_valid"}, {31'd0, o_valid}, 32'd1);
        check_eq({tag, "_hold_rdata"}, o_rdata, snap_d);
        check_eq({tag, "_hold_err"}, {31'd0, o_err}, {31'd0, snap_e});
        check_eq({tag, "_hold_ready"}, {31'd0, o_ready}, 32'd0);
      end
      t_rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq({tag, "_ready_back"}, {31'd0, o_ready}, 32'd1);
    check_eq({tag, "_valid_drop"}, {31'd0, o_valid}, 32'd0);
  endtask

  initial begin
    bit ok;
    int n;
    sel = 0;
    t_valid = 1'b0; t_we = 1'b0; t_size = 2'b00; t_signed = 1'b0;
    t_addr = 32'd0; t_wdata = 32'd0; t_rsp_ready = 1'b1;
    reset_a = 1'b1;
    reset_b = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
      check_eq("rst_err", {31'd0, o_err}, 32'd0);
      check_eq("rst_rdata", o_rdata, 32'd0);
    end
    sel = 0;
    reset_a = 1'b0;
    reset_b = 1'b0;
    @(negedge clk);
    check_eq("rst_ready_a", {31'd0, bus_a.req_ready}, 32'd1);
    check_eq("rst_ready_b", {31'd0, bus_b.req_ready}, 32'd1);

    // Big-endian, latency 2
    txn("sw_10",   1'b1, SZ_WORD, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 0);
    txn("lw_10",   1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 0);
    txn("lbs_11",  1'b0, SZ_BYTE, 1'b1, 32'h11,  32'h0,        32'hFFFFFFAD, 1'b0, 0);
    txn("lbu_11",  1'b0, SZ_BYTE, 1'b0, 32'h11,  32'h0,        32'h000000AD, 1'b0, 0);
    txn("lhu_12",  1'b0, SZ_HALF, 1'b0, 32'h12,  32'h0,        32'h0000BEEF, 1'b0, 0);
    txn("lhs_10",  1'b0, SZ_HALF, 1'b1, 32'h10,  32'h0,        32'hFFFFDEAD, 1'b0, 0);
    txn("sb_13",   1'b1, SZ_BYTE, 1'b0, 32'h13,  32'hFFFFFF5A, 32'h0,        1'b0, 0);
    txn("lw_10b",  1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        32'hDEADBE5A, 1'b0, 0);
    txn("lw_12",   1'b0, SZ_WORD, 1'b0, 32'h12,  32'h0,        32'h0,        1'b1, 0);
    txn("lh_03",   1'b0, SZ_HALF, 1'b0, 32'h03,  32'h0,        32'h0,        1'b1, 0);
    txn("ill_ld",  1'b0, SZ_ILL,  1'b0, 32'h10,  32'h0,        32'h0,        1'b1, 0);
    txn("ld_1000", 1'b0, SZ_BYTE, 1'b0, 32'h1000, 32'h0,       32'h0,        1'b1, 0);
    txn("sw_1000", 1'b1, SZ_WORD, 1'b0, 32'h1000, 32'h11111111, 32'h0,       1'b1, 0);
    txn("ill_st",  1'b1, SZ_ILL,  1'b0, 32'h10,  32'h22222222, 32'h0,        1'b1, 0);
    txn("sw_12",   1'b1, SZ_WORD, 1'b0, 32'h12,  32'h33333333, 32'h0,        1'b1, 0);
    txn("sh_11",   1'b1, SZ_HALF, 1'b0, 32'h11,  32'h44444444, 32'h0,        1'b1, 0);
    txn("lw_10c",  1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        32'hDEADBE5A, 1'b0, 0);
    txn("sh_10",   1'b1, SZ_HALF, 1'b0, 32'h10,  32'h00001234, 32'h0,        1'b0, 0);
    txn("lw_10d",  1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        32'h1234BE5A, 1'b0, 0);
    txn("sw_ffc",  1'b1, SZ_WORD, 1'b0, 32'hFFC, 32'hCAFEF00D, 32'h0,        1'b0, 0);
    txn("lbu_fff", 1'b0, SZ_BYTE, 1'b0, 32'hFFF, 32'h0,        32'h0000000D, 1'b0, 0);
    txn("hold",    1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        32'h1234BE5A, 1'b0, 5);

    // Reset while a store waits: it must be dropped
    txn("sw_20_0", 1'b1, SZ_WORD, 1'b0, 32'h20,  32'h0,        32'h0,        1'b0, 0);
    issue(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h12345678, ok);
    @(negedge clk);
    reset_a = 1'b1;
    #1;
    check_eq("rst_wait_valid", {31'd0, o_valid}, 32'd0);
    @(negedge clk);
    reset_a = 1'b0;
    txn("lw_20",   1'b0, SZ_WORD, 1'b0, 32'h20,  32'h0,        32'h0,        1'b0, 0);

    // Reset while a response is pending
    t_rsp_ready = 1'b0;
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, ok);
    wait_valid(n);
    check_eq("pre_rst_valid", {31'd0, o_valid}, 32'd1);
    reset_a = 1'b1;
    #1;
    check_eq("rst_resp_valid", {31'd0, o_valid}, 32'd0);
    check_eq("rst_resp_rdata", o_rdata, 32'd0);
    @(negedge clk);
    reset_a = 1'b0;
    t_rsp_ready = 1'b1;
    txn("lw_10e",  1'b0, SZ_WORD, 1'b0, 32'h10,  32'h0,        32'h1234BE5A, 1'b0, 0);

    // Little-endian, latency 0
    sel = 1;
    txn("b_sw_0",  1'b1, SZ_WORD, 1'b0, 32'h0,   32'hAABBCCDD, 32'h0,        1'b0, 0);
    txn("b_lbu_0", 1'b0, SZ_BYTE, 1'b0, 32'h0,   32'h0,        32'h000000DD, 1'b0, 0);
    txn("b_lbs_1", 1'b0, SZ_BYTE, 1'b1, 32'h1,   32'h0,        32'hFFFFFFCC, 1'b0, 0);
    txn("b_lhs_2", 1'b0, SZ_HALF, 1'b1, 32'h2,   32'h0,        32'hFFFFAABB, 1'b0, 0);
    txn("b_sb_3",  1'b1, SZ_BYTE, 1'b0, 32'h3,   32'h00000011, 32'h0,        1'b0, 0);
    txn("b_lw_0",  1'b0, SZ_WORD, 1'b0, 32'h0,   32'h0,        32'h11BBCCDD, 1'b0, 0);
    txn("b_lw_2",  1'b0, SZ_WORD, 1'b0, 32'h2,   32'h0,        32'h0,        1'b1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
